// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package loader_pkg;

    typedef enum logic [2:0] {
        StHdrHi,
        StHdrLo,
        StData,
        StCksum,
        StDone,
        StErr
    } state_e;

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_OVF   = 2'b01;
    localparam logic [1:0] ERR_CKSUM = 2'b10;

    localparam int unsigned BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_byte_packer.sv
// Big-endian 4-byte assembler: the first accepted byte becomes bits [31:24].
// word_valid is combinational and fires together with the 4th byte.
module imem_byte_packer
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic [31:0] word_data,
    output logic        word_valid
);

    logic [1:0]  cnt_q;
    logic [23:0] shift_q;

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            cnt_q   <= 2'd0;
            shift_q <= 24'd0;
        end else if (byte_valid) begin
            cnt_q   <= cnt_q + 2'd1;
            shift_q <= {shift_q[15:0], byte_data};
        end
    end

    assign word_valid = byte_valid && (cnt_q == 2'(BYTES_PER_WORD - 1));
    assign word_data  = {shift_q, byte_data};

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed byte image into instruction memory and holds the CPU until done.
// Optional trailing XOR checksum byte: define IMEM_LOADER_CKSUM_EN.
module imem_loader
    import loader_pkg::*;
#(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    input  logic              reload,
    output logic [ADDR_W-1:0] mem_wraddr,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_wren,
    output logic              cpu_hold,
    output logic              done,
    output logic [1:0]        err
);

`ifdef IMEM_LOADER_CKSUM_EN
    localparam state_e DataDone = StCksum;
`else
    localparam state_e DataDone = StDone;
`endif

    state_e            state_q, state_d;
    logic              fire, restart, hdr_ovf, last_word;
    logic              word_valid;
    logic [31:0]       word_data;
    logic [15:0]       hdr_count, count_q;
    logic [ADDR_W-1:0] word_idx_q;
    logic [ADDR_W-1:0] mem_wraddr_q;
    logic [DATA_W-1:0] mem_data_q;
    logic              mem_wren_q;
    logic [1:0]        err_q;
`ifdef IMEM_LOADER_CKSUM_EN
    logic [7:0]        cksum_q;
    logic              cksum_ok;

    assign cksum_ok = (in_data == cksum_q);
`endif

    assign fire      = in_valid & in_ready;
    assign restart   = reload && (state_q == StDone || state_q == StErr);
    assign hdr_count = {count_q[15:8], in_data};
    assign hdr_ovf   = {1'b0, hdr_count} > 17'(DEPTH);
    assign last_word = word_valid && (16'(word_idx_q) == count_q - 16'd1);

    imem_byte_packer u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (state_q != StData),
        .byte_valid (fire && state_q == StData),
        .byte_data  (in_data),
        .word_data  (word_data),
        .word_valid (word_valid)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StHdrHi;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StHdrHi: if (fire) state_d = StHdrLo;
            StHdrLo: begin
                if (fire) begin
                    if (hdr_ovf)                state_d = StErr;
                    else if (hdr_count == 16'd0) state_d = DataDone;
                    else                        state_d = StData;
                end
            end
            StData: if (last_word) state_d = DataDone;
`ifdef IMEM_LOADER_CKSUM_EN
            StCksum: if (fire) state_d = cksum_ok ? StDone : StErr;
`endif
            StDone, StErr: if (reload) state_d = StHdrHi;
            default: state_d = StHdrHi;
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        cpu_hold = 1'b1;
        done     = 1'b0;
        case (state_q)
            StHdrHi, StHdrLo, StData, StCksum: in_ready = 1'b1;
            StDone: begin
                cpu_hold = 1'b0;
                done     = 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath: word index, header count, error code and the registered memory port.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            word_idx_q   <= '0;
            count_q      <= 16'd0;
            err_q        <= ERR_NONE;
            mem_wraddr_q <= '0;
            mem_data_q   <= '0;
            mem_wren_q   <= 1'b0;
`ifdef IMEM_LOADER_CKSUM_EN
            cksum_q      <= 8'd0;
`endif
        end else begin
            mem_wren_q <= word_valid;
            if (word_valid) begin
                mem_data_q   <= DATA_W'(word_data);
                mem_wraddr_q <= word_idx_q;
                if (!last_word) word_idx_q <= word_idx_q + ADDR_W'(1);
            end
            if (state_q == StHdrHi && fire) count_q[15:8] <= in_data;
            if (state_q == StHdrLo && fire) begin
                count_q[7:0] <= in_data;
                if (hdr_ovf) err_q <= ERR_OVF;
            end
`ifdef IMEM_LOADER_CKSUM_EN
            if (fire && (state_q == StHdrHi || state_q == StHdrLo || state_q == StData)) begin
                cksum_q <= cksum_q ^ in_data;
            end
            if (state_q == StCksum && fire && !cksum_ok) err_q <= ERR_CKSUM;
`endif
            if (restart) begin
                word_idx_q <= '0;
                count_q    <= 16'd0;
                err_q      <= ERR_NONE;
`ifdef IMEM_LOADER_CKSUM_EN
                cksum_q    <= 8'd0;
`endif
            end
        end
    end

    assign mem_wraddr = mem_wraddr_q;
    assign mem_data   = mem_data_q;
    assign mem_wren   = mem_wren_q;
    assign err        = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader; build with IMEM_LOADER_CKSUM_EN to cover the checksum variant.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst_n, in_valid, reload, in_ready;
    logic [7:0]  in_data;
    logic [9:0]  mem_wraddr;
    logic [31:0] mem_data;
    logic        mem_wren, cpu_hold, done;
    logic [1:0]  err;

    int          cyc = 0;
    int          acc_cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [9:0]  wr_addr[$];
    logic [31:0] wr_data[$];
    int          wr_cyc[$];

    imem_loader #(
        .ADDR_W (10),
        .DATA_W (32),
        .DEPTH  (1024)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .reload     (reload),
        .mem_wraddr (mem_wraddr),
        .mem_data   (mem_data),
        .mem_wren   (mem_wren),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    // Write log, sampled on the falling edge.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (mem_wren) begin
            wr_addr.push_back(mem_wraddr);
            wr_data.push_back(mem_data);
            wr_cyc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = b;
            if (in_ready) begin
                @(posedge clk);
                acc_cyc = cyc;
                ok = 1'b1;
            end
        end
        if (!ok) begin
            check("accept_timeout", 32'd0, 32'd1);
            in_valid = 1'b0;
        end
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        reload   = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic pulse_reload();
        @(negedge clk);
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
        wr_cyc.delete();
    endtask

    int last_acc, first_acc;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; reload = 1'b0; in_data = 8'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Reset state
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_wren", 32'(mem_wren), 32'd0);
        check("rst_wraddr", 32'(mem_wraddr), 32'd0);
        check("rst_data", mem_data, 32'd0);
        check("rst_hold", 32'(cpu_hold), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);

        // 1: N=2 frame
        clear_log();
        send_byte(8'h00); send_byte(8'h02);
        send_byte(8'h20); send_byte(8'h01); send_byte(8'h00); send_byte(8'h05);
        send_byte(8'hAC); send_byte(8'h01); send_byte(8'h00); send_byte(8'h00);
        last_acc = acc_cyc;
        idle();
        check("t1_wren_latency", 32'(mem_wren), 32'd1);
`ifdef IMEM_LOADER_CKSUM_EN
        check("t1_done_before_ck", 32'(done), 32'd0);
        send_byte(8'h8B);
        idle();
`else
        check("t1_done_latency", 32'(done), 32'd1);
`endif
        repeat (2) @(negedge clk);
        check("t1_nwr", 32'(wr_addr.size()), 32'd2);
        if (wr_addr.size() == 2) begin
            check("t1_addr0", 32'(wr_addr[0]), 32'd0);
            check("t1_data0", wr_data[0], 32'h20010005);
            check("t1_addr1", 32'(wr_addr[1]), 32'd1);
            check("t1_data1", wr_data[1], 32'hAC010000);
            check("t1_wr_cyc", 32'(wr_cyc[1]), 32'(last_acc + 1));
        end
        check("t1_done", 32'(done), 32'd1);
        check("t1_hold", 32'(cpu_hold), 32'd0);
        check("t1_ready", 32'(in_ready), 32'd0);
        check("t1_err", 32'(err), 32'd0);

        // 2: empty image
        pulse_reload();
        check("rl_done", 32'(done), 32'd0);
        check("rl_hold", 32'(cpu_hold), 32'd1);
        check("rl_ready", 32'(in_ready), 32'd1);
        clear_log();
        send_byte(8'h00); send_byte(8'h00);
        idle();
`ifdef IMEM_LOADER_CKSUM_EN
        check("t2_done_before_ck", 32'(done), 32'd0);
        send_byte(8'h00);
        idle();
`endif
        check("t2_done", 32'(done), 32'd1);
        repeat (3) @(negedge clk);
        check("t2_nwr", 32'(wr_addr.size()), 32'd0);

        // 3: overflow 1025 words, then a held byte must not be consumed
        pulse_reload();
        clear_log();
        send_byte(8'h04); send_byte(8'h01);
        idle();
        check("t3_err", 32'(err), 32'd1);
        check("t3_hold", 32'(cpu_hold), 32'd1);
        check("t3_ready", 32'(in_ready), 32'd0);
        check("t3_done", 32'(done), 32'd0);
        in_valid = 1'b1; in_data = 8'h55;
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        check("t3_err_held", 32'(err), 32'd1);
        check("t3_nwr", 32'(wr_addr.size()), 32'd0);
        pulse_reload();
        check("t3_rl_err", 32'(err), 32'd0);
        check("t3_rl_ready", 32'(in_ready), 32'd1);

        // 4: continuous stream, N=3
        clear_log();
        send_byte(8'h00);
        first_acc = acc_cyc;
        send_byte(8'h03);
        for (int i = 1; i <= 12; i++) send_byte(8'(i));
        last_acc = acc_cyc;
`ifdef IMEM_LOADER_CKSUM_EN
        send_byte(8'h0F);
`endif
        idle();
        repeat (2) @(negedge clk);
        check("t4_stream_rate", 32'(last_acc - first_acc), 32'd13);
        check("t4_nwr", 32'(wr_addr.size()), 32'd3);
        if (wr_addr.size() == 3) begin
            check("t4_addr0", 32'(wr_addr[0]), 32'd0);
            check("t4_addr1", 32'(wr_addr[1]), 32'd1);
            check("t4_addr2", 32'(wr_addr[2]), 32'd2);
            check("t4_data0", wr_data[0], 32'h01020304);
            check("t4_data1", wr_data[1], 32'h05060708);
            check("t4_data2", wr_data[2], 32'h090A0B0C);
            check("t4_gap01", 32'(wr_cyc[1] - wr_cyc[0]), 32'd4);
            check("t4_gap12", 32'(wr_cyc[2] - wr_cyc[1]), 32'd4);
            check("t4_last_lat", 32'(wr_cyc[2]), 32'(last_acc + 1));
        end
        check("t4_done", 32'(done), 32'd1);

        // Boundary: N=DEPTH is accepted
        pulse_reload();
        send_byte(8'h04); send_byte(8'h00);
        idle();
        check("b_err", 32'(err), 32'd0);
        check("b_ready", 32'(in_ready), 32'd1);
        check("b_done", 32'(done), 32'd0);
        do_reset();

        // 5: reset mid-word, then a fresh N=1 frame
        send_byte(8'h00); send_byte(8'h01); send_byte(8'hAA); send_byte(8'hBB);
        do_reset();
        check("t5_wraddr", 32'(mem_wraddr), 32'd0);
        check("t5_data", mem_data, 32'd0);
        check("t5_ready", 32'(in_ready), 32'd1);
        clear_log();
        send_byte(8'h00); send_byte(8'h01);
        send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
`ifdef IMEM_LOADER_CKSUM_EN
        send_byte(8'h23);
`endif
        idle();
        repeat (2) @(negedge clk);
        check("t5_nwr", 32'(wr_addr.size()), 32'd1);
        if (wr_addr.size() == 1) begin
            check("t5_addr", 32'(wr_addr[0]), 32'd0);
            check("t5_wdata", wr_data[0], 32'hDEADBEEF);
        end
        check("t5_done", 32'(done), 32'd1);

`ifdef IMEM_LOADER_CKSUM_EN
        // 6: checksum match and mismatch
        pulse_reload();
        send_byte(8'h00); send_byte(8'h01);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        send_byte(8'h45);
        idle();
        check("t6_ok_done", 32'(done), 32'd1);
        check("t6_ok_err", 32'(err), 32'd0);
        pulse_reload();
        send_byte(8'h00); send_byte(8'h01);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        send_byte(8'h46);
        idle();
        check("t6_bad_err", 32'(err), 32'd2);
        check("t6_bad_done", 32'(done), 32'd0);
        check("t6_bad_hold", 32'(cpu_hold), 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
